// File: rtl/mem_stream_loader.sv
// Streams a window of memory words into a DUT write port (optionally over several
// passes), then holds chip select until the DUT reports a result or a timeout expires.
module mem_stream_loader #(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CNT_WIDTH    = 11,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned HOLD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic [3:0]            repeat_count,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic                  chip_sel,
    input  logic                  output_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  words_sent
);
    localparam int unsigned WAIT_W = 2;
    localparam int unsigned HOLD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_HOLD, S_DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  wc_q;
    logic [3:0]            passes_q;
    logic [CNT_WIDTH-1:0]  offset_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_en_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  wr_en_q;
    logic                  chip_sel_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  timeout_err_q;
    logic [CNT_WIDTH-1:0]  words_sent_q;

    logic                  last_word_c;
    logic [CNT_WIDTH-1:0]  next_off_c;

    assign last_word_c = (offset_q == wc_q - CNT_WIDTH'(1));
    assign next_off_c  = offset_q + CNT_WIDTH'(1);

    // Transfer sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            wc_q          <= '0;
            passes_q      <= '0;
            offset_q      <= '0;
            wait_q        <= '0;
            hold_q        <= '0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            data_out_q    <= '0;
            wr_en_q       <= 1'b0;
            chip_sel_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            words_sent_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                chip_sel_q  <= 1'b0;
                wr_en_q     <= 1'b0;
                mem_rd_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            base_q        <= base_addr;
                            wc_q          <= word_count;
                            passes_q      <= (repeat_count == 4'd0) ? 4'd1 : repeat_count;
                            offset_q      <= '0;
                            words_sent_q  <= '0;
                            timeout_err_q <= 1'b0;
                            busy_q        <= 1'b1;
                            if (word_count != '0) begin
                                state_q     <= S_READ;
                                chip_sel_q  <= 1'b1;
                                mem_rd_en_q <= 1'b1;
                                mem_addr_q  <= base_addr;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        mem_rd_en_q <= 1'b0;
                        wait_q      <= '0;
                        state_q     <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_q == WAIT_W'(RD_LATENCY - 1)) begin
                            data_out_q <= mem_data_in;
                            wr_en_q    <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (wr_ready) begin
                            wr_en_q <= 1'b0;
                            state_q <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (last_word_c) begin
                            offset_q <= '0;
                            passes_q <= passes_q - 4'd1;
                            if (passes_q > 4'd1) begin
                                words_sent_q <= '0;
                                mem_rd_en_q  <= 1'b1;
                                mem_addr_q   <= base_q;
                                state_q      <= S_READ;
                            end else begin
                                words_sent_q <= words_sent_q + CNT_WIDTH'(1);
                                hold_q       <= '0;
                                state_q      <= S_HOLD;
                            end
                        end else begin
                            offset_q     <= next_off_c;
                            words_sent_q <= words_sent_q + CNT_WIDTH'(1);
                            mem_rd_en_q  <= 1'b1;
                            mem_addr_q   <= base_q + ADDR_WIDTH'(next_off_c);
                            state_q      <= S_READ;
                        end
                    end
                    S_HOLD: begin
                        if (output_ready) begin
                            chip_sel_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else if (hold_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
                            chip_sel_q    <= 1'b0;
                            timeout_err_q <= 1'b1;
                            done_q        <= 1'b1;
                            state_q       <= S_DONE;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign data_out    = data_out_q;
    assign wr_en       = wr_en_q;
    assign chip_sel    = chip_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign words_sent  = words_sent_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Bench for mem_stream_loader: two instances (read latency 1 and 3) share stimulus and
// are compared against an address/data sequence model built from the transfer rules.
module tb_mem_stream_loader;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 11;
    localparam int unsigned HT = 255;

    logic          clk          = 1'b0;
    logic          reset        = 1'b1;
    logic          start        = 1'b0;
    logic          abort        = 1'b0;
    logic          wr_ready     = 1'b1;
    logic          output_ready = 1'b1;
    logic [AW-1:0] base_addr    = '0;
    logic [CW-1:0] word_count   = '0;
    logic [3:0]    repeat_count = '0;

    logic [AW-1:0] mem_addr    [2];
    logic          mem_rd_en   [2];
    logic [DW-1:0] mem_data_in [2];
    logic [DW-1:0] data_out    [2];
    logic          wr_en       [2];
    logic          chip_sel    [2];
    logic          busy        [2];
    logic          done        [2];
    logic          timeout_err [2];
    logic [CW-1:0] words_sent  [2];

    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [3];

    int n_test = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [AW-1:0] rd0[$], rd1[$], exp_addr[$];
    logic [DW-1:0] wr0[$], wr1[$];
    int done_n[2], done_cyc[2], first_rd[2], last_wr[2], cs_gap[2], cs_cnt[2];
    int lat[2] = '{1, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RD_LATENCY(1), .HOLD_TIMEOUT(HT)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .repeat_count(repeat_count), .abort(abort), .mem_addr(mem_addr[0]), .mem_rd_en(mem_rd_en[0]),
        .mem_data_in(mem_data_in[0]), .data_out(data_out[0]), .wr_en(wr_en[0]), .wr_ready(wr_ready),
        .chip_sel(chip_sel[0]), .output_ready(output_ready), .busy(busy[0]), .done(done[0]),
        .timeout_err(timeout_err[0]), .words_sent(words_sent[0]));

    mem_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .RD_LATENCY(3), .HOLD_TIMEOUT(HT)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .repeat_count(repeat_count), .abort(abort), .mem_addr(mem_addr[1]), .mem_rd_en(mem_rd_en[1]),
        .mem_data_in(mem_data_in[1]), .data_out(data_out[1]), .wr_en(wr_en[1]), .wr_ready(wr_ready),
        .chip_sel(chip_sel[1]), .output_ready(output_ready), .busy(busy[1]), .done(done[1]),
        .timeout_err(timeout_err[1]), .words_sent(words_sent[1]));

    // Memories return valid data only in the read-latency slot; other cycles carry junk.
    always @(posedge clk) begin
        pipe0    <= mem_rd_en[0] ? mem[mem_addr[0]] : DW'($urandom);
        pipe1[0] <= mem_rd_en[1] ? mem[mem_addr[1]] : DW'($urandom);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mem_data_in[0] = pipe0;
    assign mem_data_in[1] = pipe1[2];

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                if (mem_rd_en[k]) begin
                    if (first_rd[k] < 0) first_rd[k] = cyc;
                    if (k == 0) rd0.push_back(mem_addr[k]); else rd1.push_back(mem_addr[k]);
                end
                if (wr_en[k] && wr_ready) begin
                    last_wr[k] = cyc;
                    if (k == 0) wr0.push_back(data_out[k]); else wr1.push_back(data_out[k]);
                end
                if (done[k]) begin
                    done_n[k]++;
                    done_cyc[k] = cyc;
                end
                if (busy[k] && !done[k] && !chip_sel[k]) cs_gap[k]++;
                if (chip_sel[k]) cs_cnt[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd0.delete(); rd1.delete(); wr0.delete(); wr1.delete();
        for (int k = 0; k < 2; k++) begin
            done_n[k] = 0; done_cyc[k] = -1; first_rd[k] = -1; last_wr[k] = -1;
            cs_gap[k] = 0; cs_cnt[k] = 0;
        end
    endtask

    task automatic model_xfer(input int b, input int wc, input int rc);
        int passes;
        passes = (rc == 0) ? 1 : rc;
        exp_addr.delete();
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < wc; i++) exp_addr.push_back(AW'((b + i) % (1 << AW)));
    endtask

    task automatic launch(input int b, input int wc, input int rc);
        base_addr = AW'(b); word_count = CW'(wc); repeat_count = 4'(rc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!busy[0] && !busy[1]) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    function automatic int log_errs(input logic [AW-1:0] rq[$], input logic [DW-1:0] wq[$]);
        int e;
        e = 0;
        if (rq.size() != exp_addr.size() || wq.size() != exp_addr.size()) return 1000 + rq.size();
        foreach (exp_addr[i]) if (rq[i] !== exp_addr[i] || wq[i] !== mem[exp_addr[i]]) e++;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            n_test++;
            if ({busy[k], done[k], chip_sel[k], wr_en[k], mem_rd_en[k], timeout_err[k], data_out[k], mem_addr[k], words_sent[k]} !== '0) begin
                n_fail++; $display("FAIL reset_outputs dut%0d: got nonzero outputs, want all 0", k);
            end
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_long();
        bit ok; int errs[2];
        output_ready = 1'b1; wr_ready = 1'b1;
        clear_logs(); model_xfer(0, 66, 1);
        launch(0, 66, 1);
        wait_idle(2000, ok);
        n_test++; if (!ok) begin n_fail++; $display("FAIL long_timeout: got busy, want idle within 2000 cycles"); end
        errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (errs[k] != 0) begin n_fail++; $display("FAIL long_data dut%0d: got %0d errors, want 0", k, errs[k]); end
            n_test++; if (done_cyc[k] - first_rd[k] != 66 * (3 + lat[k]) + 1) begin
                n_fail++; $display("FAIL long_cycles dut%0d: got %0d, want %0d", k, done_cyc[k] - first_rd[k], 66 * (3 + lat[k]) + 1);
            end
            n_test++; if (done_n[k] != 1 || words_sent[k] !== CW'(66) || cs_gap[k] != 0) begin
                n_fail++; $display("FAIL long_status dut%0d: got done=%0d sent=%0d gap=%0d, want 1 66 0", k, done_n[k], words_sent[k], cs_gap[k]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok; int errs[2];
        clear_logs(); model_xfer(2046, 4, 1);
        launch(2046, 4, 1);
        wait_idle(200, ok);
        n_test++; if (!ok || rd0.size() != 4 || rd0[2] !== AW'(0) || rd0[3] !== AW'(1)) begin
            n_fail++; $display("FAIL wrap_addr: got ok=%0d n=%0d, want addresses 2046 2047 0 1", ok, rd0.size());
        end
        errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (errs[k] != 0) begin n_fail++; $display("FAIL wrap_data dut%0d: got %0d errors, want 0", k, errs[k]); end
        end
    endtask

    task automatic test_stall();
        bit ok; int errs[2]; int b, cnt, bad; logic [DW-1:0] held;
        b = $urandom_range(0, 2047);
        clear_logs(); model_xfer(b, 4, 1);
        launch(b, 4, 1);
        for (int i = 0; i < 100 && wr1.size() < 1; i++) tick();
        wr_ready = 1'b0;
        cnt = 0; bad = 0; held = '0;
        for (int i = 0; i < 100; i++) begin
            if (wr_en[1]) begin
                if (cnt == 0) held = data_out[1];
                else if (data_out[1] !== held) bad++;
                cnt++;
            end
            if (cnt == 6) break;
            tick();
        end
        wr_ready = 1'b1;
        tick();
        n_test++; if (cnt != 6 || wr_en[1] !== 1'b0) begin
            n_fail++; $display("FAIL stall_wr_en: got %0d cycles (wr_en now %0b), want 6 then 0", cnt, wr_en[1]);
        end
        n_test++; if (bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes, want 0", bad); end
        wait_idle(300, ok);
        errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (!ok || errs[k] != 0 || done_n[k] != 1) begin
                n_fail++; $display("FAIL stall_data dut%0d: got ok=%0d errs=%0d done=%0d, want 1 0 1", k, ok, errs[k], done_n[k]);
            end
        end
    endtask

    task automatic test_repeat();
        bit ok; int errs[2]; int b;
        b = $urandom_range(0, 2047);
        clear_logs(); model_xfer(b, 2, 3);
        launch(b, 2, 3);
        repeat (3) tick();
        base_addr = AW'(b + 100); word_count = CW'(5); start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(300, ok);
        errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (!ok || errs[k] != 0) begin n_fail++; $display("FAIL repeat_data dut%0d: got ok=%0d errs=%0d, want 1 0", k, ok, errs[k]); end
            n_test++; if (done_n[k] != 1 || cs_gap[k] != 0) begin
                n_fail++; $display("FAIL repeat_status dut%0d: got done=%0d gap=%0d, want 1 0", k, done_n[k], cs_gap[k]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok; int errs[2]; int b;
        b = $urandom_range(0, 2047);
        output_ready = 1'b0;
        clear_logs(); model_xfer(b, 3, 1);
        launch(b, 3, 1);
        wait_idle(1000, ok);
        errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (!ok || errs[k] != 0 || timeout_err[k] !== 1'b1 || chip_sel[k] !== 1'b0 || done_n[k] != 1) begin
                n_fail++; $display("FAIL timeout_flag dut%0d: got ok=%0d errs=%0d err=%0b cs=%0b done=%0d, want 1 0 1 0 1",
                                   k, ok, errs[k], timeout_err[k], chip_sel[k], done_n[k]);
            end
            n_test++; if (done_cyc[k] - last_wr[k] != HT + 2) begin
                n_fail++; $display("FAIL timeout_len dut%0d: got %0d, want %0d", k, done_cyc[k] - last_wr[k], HT + 2);
            end
        end
        output_ready = 1'b1;
        clear_logs(); model_xfer(b, 1, 1);
        launch(b, 1, 1);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (timeout_err[k] !== 1'b0) begin n_fail++; $display("FAIL timeout_clear dut%0d: got %0b, want 0", k, timeout_err[k]); end
        end
        wait_idle(200, ok);
        for (int k = 0; k < 2; k++) begin
            n_test++; if (!ok || done_cyc[k] - last_wr[k] != 3 || timeout_err[k] !== 1'b0) begin
                n_fail++; $display("FAIL hold_ready dut%0d: got %0d err=%0b, want 3 0", k, done_cyc[k] - last_wr[k], timeout_err[k]);
            end
        end
    endtask

    task automatic test_abort();
        int b, bad;
        b = $urandom_range(0, 2047);
        output_ready = 1'b1;
        clear_logs(); model_xfer(b, 20, 1);
        launch(b, 20, 1);
        for (int i = 0; i < 500 && wr0.size() < 10; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_test++; if ({busy[k], chip_sel[k], wr_en[k], mem_rd_en[k], done[k]} !== 5'b0) begin
                n_fail++; $display("FAIL abort_idle dut%0d: got %05b, want 00000", k, {busy[k], chip_sel[k], wr_en[k], mem_rd_en[k], done[k]});
            end
        end
        repeat (10) tick();
        bad = 0;
        foreach (wr1[i]) if (wr1[i] !== mem[exp_addr[i]]) bad++;
        n_test++; if (wr0.size() != 10 || done_n[0] != 0 || done_n[1] != 0 || bad != 0) begin
            n_fail++; $display("FAIL abort_result: got words=%0d done=%0d/%0d bad=%0d, want 10 0/0 0", wr0.size(), done_n[0], done_n[1], bad);
        end
    endtask

    task automatic test_zero();
        clear_logs();
        launch($urandom_range(0, 2047), 0, $urandom_range(0, 3));
        for (int k = 0; k < 2; k++) begin
            n_test++; if ({done[k], busy[k], chip_sel[k]} !== 3'b110) begin
                n_fail++; $display("FAIL zero_done dut%0d: got done,busy,cs=%03b, want 110", k, {done[k], busy[k], chip_sel[k]});
            end
        end
        tick();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            n_test++; if (busy[k] !== 1'b0 || done_n[k] != 1 || cs_cnt[k] != 0) begin
                n_fail++; $display("FAIL zero_after dut%0d: got busy=%0b done=%0d cs=%0d, want 0 1 0", k, busy[k], done_n[k], cs_cnt[k]);
            end
        end
        n_test++; if (rd0.size() + rd1.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d, want 0", rd0.size() + rd1.size()); end
    endtask

    task automatic test_random();
        bit ok; int errs[2]; int b, wc, rc;
        for (int it = 0; it < 6; it++) begin
            b = $urandom_range(0, 2047); wc = $urandom_range(1, 9); rc = $urandom_range(0, 3);
            clear_logs(); model_xfer(b, wc, rc);
            launch(b, wc, rc);
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (!busy[0] && !busy[1]) begin ok = 1'b1; break; end
                wr_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            wr_ready = 1'b1;
            errs[0] = log_errs(rd0, wr0); errs[1] = log_errs(rd1, wr1);
            for (int k = 0; k < 2; k++) begin
                n_test++; if (!ok || errs[k] != 0 || done_n[k] != 1 || words_sent[k] !== CW'(wc) || timeout_err[k] !== 1'b0) begin
                    n_fail++; $display("FAIL random_%0d dut%0d: got ok=%0d errs=%0d done=%0d sent=%0d, want 1 0 1 %0d",
                                       it, k, ok, errs[k], done_n[k], words_sent[k], wc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        launch($urandom_range(0, 2047), 30, 1);
        repeat (20) tick();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_test++; if ({busy[k], chip_sel[k], wr_en[k], mem_rd_en[k], data_out[k], mem_addr[k], words_sent[k]} !== '0) begin
                n_fail++; $display("FAIL reset_async dut%0d: got nonzero outputs, want all 0", k);
            end
        end
        repeat (2) tick();
        reset = 1'b1;
        clear_logs();
        repeat (5) tick();
        n_test++; if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || rd0.size() + rd1.size() != 0) begin
            n_fail++; $display("FAIL reset_restart: got busy=%0b/%0b reads=%0d, want 0/0 0", busy[0], busy[1], rd0.size() + rd1.size());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        clear_logs();
        test_reset();
        test_long();
        test_wrap();
        test_stall();
        test_repeat();
        test_timeout();
        test_abort();
        test_zero();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, want finish before 2000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
